// File: rtl/phys_reg_free_list.sv
// Circular free list of physical register tags: rename pops, commit pushes, flush restores to full.
// Optional protocol checking and overflow protection is enabled by defining FREE_LIST_CHECK_EN.
module phys_reg_free_list #(
    parameter int SS        = 2,
    parameter int PHYS_REGS = 64,
    parameter int ARCH_REGS = 32,
    localparam int TAG_W    = $clog2(PHYS_REGS),
    localparam int CAP      = PHYS_REGS - ARCH_REGS,
    localparam int IDX_W    = $clog2(CAP),
    localparam int PTR_W    = IDX_W + 1,
    localparam int CNT_W    = IDX_W + 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [SS-1:0]              deq_req,
    output logic                       deq_valid,
    output logic [SS-1:0][TAG_W-1:0]   deq_preg,
    input  logic [SS-1:0]              enq_we,
    input  logic [SS-1:0][TAG_W-1:0]   enq_preg,
    input  logic                       flush,
    output logic [CNT_W-1:0]           count,
    output logic                       empty,
    output logic                       err
);

    logic [TAG_W-1:0] storage_q [CAP];
    logic [TAG_W-1:0] storage_d [CAP];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W-1:0] count_p;
    logic [PTR_W-1:0] deq_cnt, enq_cnt, deq_n;
    logic [IDX_W-1:0] rd_idx, wr_idx, wr_off;
    logic             grant;
    logic             enq_ok;

`ifdef FREE_LIST_CHECK_EN
    logic err_q, err_d;
    logic overflow, tag_zero;
`endif

    always_comb begin
        count_p   = tail_q - head_q;
        count     = CNT_W'(count_p);
        deq_valid = (count >= CNT_W'(SS));
        empty     = (count == '0);
        grant     = deq_valid && !flush;
        deq_cnt   = '0;
        enq_cnt   = '0;
        rd_idx    = '0;
        // Requested ways are compacted: each set bit takes the next tag from head.
        for (int i = 0; i < SS; i++) begin
            rd_idx      = head_q[IDX_W-1:0] + deq_cnt[IDX_W-1:0];
            deq_preg[i] = deq_valid ? storage_q[rd_idx] : 'x;
            deq_cnt     = deq_cnt + PTR_W'(deq_req[i]);
            enq_cnt     = enq_cnt + PTR_W'(enq_we[i]);
        end
        deq_n = grant ? deq_cnt : '0;

`ifdef FREE_LIST_CHECK_EN
        overflow = ((count + CNT_W'(enq_cnt) - CNT_W'(deq_n)) > CNT_W'(CAP));
        tag_zero = 1'b0;
        for (int i = 0; i < SS; i++) begin
            if (enq_we[i] && (enq_preg[i] == '0)) tag_zero = 1'b1;
        end
        err_d  = err_q | overflow | tag_zero | ((|deq_req) && !deq_valid);
        enq_ok = !overflow;
`else
        enq_ok = 1'b1;
`endif

        storage_d = storage_q;
        wr_off    = '0;
        wr_idx    = '0;
        if (enq_ok) begin
            for (int i = 0; i < SS; i++) begin
                if (enq_we[i]) begin
                    wr_idx            = tail_q[IDX_W-1:0] + wr_off;
                    storage_d[wr_idx] = enq_preg[i];
                    wr_off            = wr_off + IDX_W'(1);
                end
            end
        end
        tail_d = enq_ok ? (tail_q + enq_cnt) : tail_q;
        // Slots behind the tail still hold speculatively popped tags, so a flush
        // only needs to pull head a full lap behind the post-enqueue tail.
        head_d = flush ? {~tail_d[IDX_W], tail_d[IDX_W-1:0]} : (head_q + deq_n);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < CAP; i++) storage_q[i] <= TAG_W'(ARCH_REGS + i);
            head_q <= '0;
            tail_q <= {1'b1, {IDX_W{1'b0}}};
        end else begin
            storage_q <= storage_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
        end
    end

`ifdef FREE_LIST_CHECK_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) err_q <= 1'b0;
        else      err_q <= err_d;
    end

    assign err = err_q;

    count_bound_a: assert property (@(posedge clk) disable iff (!rst) count <= CNT_W'(CAP));
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Directed bench for phys_reg_free_list: reset image, drain, boundary, wrap, flush, reset mid-operation.
module tb_phys_reg_free_list;
    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      deq_req;
    logic            deq_valid;
    logic [1:0][5:0] deq_preg;
    logic [1:0]      enq_we;
    logic [1:0][5:0] enq_preg;
    logic            flush;
    logic [6:0]      count;
    logic            empty;
    logic            err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    phys_reg_free_list #(.SS(2), .PHYS_REGS(64), .ARCH_REGS(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .deq_req   (deq_req),
        .deq_valid (deq_valid),
        .deq_preg  (deq_preg),
        .enq_we    (enq_we),
        .enq_preg  (enq_preg),
        .flush     (flush),
        .count     (count),
        .empty     (empty),
        .err       (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

`ifdef FREE_LIST_CHECK_EN
    localparam logic ERR_AFTER_BAD_DEQ = 1'b1;
`else
    localparam logic ERR_AFTER_BAD_DEQ = 1'b0;
`endif

    initial begin
        rst      = 1'b0;
        deq_req  = 2'b00;
        enq_we   = 2'b00;
        enq_preg = '0;
        flush    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count_held", count, 32);
        #2 rst = 1'b1;
        #1;
        chk("rst_count", count, 32);
        chk("rst_deq_valid", deq_valid, 1);
        chk("rst_empty", empty, 0);
        chk("rst_err", err, 0);

        deq_req = 2'b11;
        #1;
        chk("rst_deq0", deq_preg[0], 32);
        chk("rst_deq1", deq_preg[1], 33);
        deq_req = 2'b10;
        #1;
        chk("compact_way1", deq_preg[1], 32);
        deq_req = 2'b01;
        #1;
        chk("compact_way0", deq_preg[0], 32);

        deq_req = 2'b11;
        tick;
        chk("pop1_count", count, 30);
        chk("pop1_deq0", deq_preg[0], 34);
        chk("pop1_deq1", deq_preg[1], 35);

        for (int i = 0; i < 15; i++) tick;
        chk("drain_count", count, 0);
        chk("drain_empty", empty, 1);
        chk("drain_valid", deq_valid, 0);
        tick;
        chk("stall_count", count, 0);
        chk("stall_err", err, ERR_AFTER_BAD_DEQ);

        deq_req     = 2'b00;
        enq_we      = 2'b01;
        enq_preg[0] = 6'd4;
        tick;
        chk("one_count", count, 1);
        chk("one_valid", deq_valid, 0);
        chk("one_empty", empty, 0);

        deq_req     = 2'b11;
        enq_we      = 2'b10;
        enq_preg[0] = 6'd0;
        enq_preg[1] = 6'd5;
        tick;
        enq_we = 2'b00;
        #1;
        chk("bnd_count", count, 2);
        chk("bnd_valid", deq_valid, 1);
        chk("bnd_deq0", deq_preg[0], 4);
        chk("bnd_deq1", deq_preg[1], 5);

        for (int j = 0; j < 20; j++) begin
            chk("wrap_deq0", deq_preg[0], (j == 0) ? 4 : 2 * (j - 1) + 10);
            chk("wrap_deq1", deq_preg[1], (j == 0) ? 5 : 2 * (j - 1) + 11);
            tick;
            chk("wrap_pop_count", count, 0);
            deq_req     = 2'b00;
            enq_we      = 2'b11;
            enq_preg[0] = 6'(2 * j + 10);
            enq_preg[1] = 6'(2 * j + 11);
            tick;
            chk("wrap_push_count", count, 2);
            enq_we  = 2'b00;
            deq_req = 2'b11;
            #1;
        end
        chk("wrap_end_deq0", deq_preg[0], 48);
        chk("wrap_end_deq1", deq_preg[1], 49);

        flush       = 1'b1;
        enq_we      = 2'b01;
        enq_preg[0] = 6'd7;
        tick;
        flush  = 1'b0;
        enq_we = 2'b00;
        #1;
        chk("flush_count", count, 32);
        chk("flush_deq0", deq_preg[0], 19);
        chk("flush_deq1", deq_preg[1], 20);
        tick;
        chk("post_flush_count", count, 30);
        chk("post_flush_deq0", deq_preg[0], 21);
        chk("post_flush_deq1", deq_preg[1], 22);

        deq_req     = 2'b00;
        enq_we      = 2'b11;
        enq_preg[0] = 6'd50;
        enq_preg[1] = 6'd51;
        tick;
        enq_we = 2'b00;
        #1;
        chk("refill_count", count, 32);
`ifdef FREE_LIST_CHECK_EN
        enq_we      = 2'b01;
        enq_preg[0] = 6'd9;
        tick;
        enq_we = 2'b00;
        #1;
        chk("ovf_count", count, 32);
        chk("ovf_err", err, 1);
`else
        chk("noerr_default", err, 0);
`endif

        enq_we   = 2'b11;
        enq_preg = {6'd12, 6'd13};
        flush    = 1'b1;
        deq_req  = 2'b11;
        rst      = 1'b0;
        #1;
        chk("midrst_count", count, 32);
        chk("midrst_deq0", deq_preg[0], 32);
        chk("midrst_deq1", deq_preg[1], 33);
        chk("midrst_err", err, 0);
        enq_we  = 2'b00;
        flush   = 1'b0;
        deq_req = 2'b00;
        #1 rst = 1'b1;
        tick;
        chk("midrst_hold_count", count, 32);
        chk("midrst_hold_valid", deq_valid, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
